// File: rtl/ets_phase_sweep.sv
// ets_phase_sweep: equivalent-time sampling sweep sequencer.
//
// Steps the MMCM fine phase shift one increment at a time. At each phase it counts the '1'
// bits in 2**ACC_LOG2 received words and emits one (phase, count) point over a valid/ready
// stream. rx words arrive already re-timed into free_run_clk, and ps_clk is tied to
// free_run_clk, so the whole block runs on a single clock.
//
// Optional feature (macro ETS_PS_RETURN_EN): after the last point, walk the MMCM phase back
// to the starting offset with STEPS-1 decrement steps before pulsing done.
//
// Ports:
//   free_run_clk, free_run_rst  clock and asynchronous active-high reset
//   start, abort                1-cycle control pulses
//   locked                      MMCM lock status
//   ps_en, ps_incdec, ps_done   MMCM dynamic phase-shift handshake
//   smp_valid, smp_data         rx word stream
//   out_valid, out_ready        point stream handshake
//   out_phase, out_count        point payload; out_last flags the final point
//   busy, done, err             status (done is a pulse, err is sticky until next start)
module ets_phase_sweep #(
  parameter int unsigned STEPS      = 448,
  parameter int unsigned ACC_LOG2   = 10,
  parameter int unsigned SETTLE_CYC = 64,   // must be >= 1
  parameter int unsigned PS_TIMEOUT = 1023  // must be >= 1
) (
  input  logic                free_run_clk,
  input  logic                free_run_rst,
  input  logic                start,
  input  logic                abort,
  input  logic                locked,
  output logic                ps_en,
  output logic                ps_incdec,
  input  logic                ps_done,
  input  logic                smp_valid,
  input  logic [7:0]          smp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_phase,
  output logic [ACC_LOG2+3:0] out_count,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned AccW   = ACC_LOG2 + 4;
  localparam int unsigned WcntW  = ACC_LOG2 + 1;
  localparam int unsigned TmrMax = (PS_TIMEOUT > SETTLE_CYC) ? PS_TIMEOUT : SETTLE_CYC;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [WcntW-1:0] WordLast   = WcntW'((1 << ACC_LOG2) - 1);
  localparam logic [TmrW-1:0]  TmrTimeout = TmrW'(PS_TIMEOUT - 1);
  localparam logic [TmrW-1:0]  SettleLast = TmrW'(SETTLE_CYC - 1);
  localparam logic [15:0]      PhaseLast  = 16'(STEPS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StEmit,
    StShift,
    StWaitPs,
    StSettle
`ifdef ETS_PS_RETURN_EN
    ,
    StReturn,
    StWaitRet
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       phase_q, phase_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  always_ff @(posedge free_run_clk or posedge free_run_rst) begin
    if (free_run_rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (state_q == StIdle) begin
      // Stray ps_done after an aborted step lands here and is ignored.
      if (start && !abort) begin
        if (locked) begin
          state_d = StAccum;
          err_d   = 1'b0;
          phase_d = '0;
          acc_d   = '0;
          wcnt_d  = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (abort) begin
      // Phase offset is deliberately left wherever the MMCM currently is.
      state_d = StIdle;
    end else if (!locked) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        StAccum: begin
          if (smp_valid) begin
            acc_d  = acc_q + AccW'(popcount8(smp_data));
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == WordLast) begin
              state_d = StEmit;
            end
          end
        end
        StEmit: begin
          if (out_ready) begin
            if (phase_q == PhaseLast) begin
`ifdef ETS_PS_RETURN_EN
              if (phase_q != 16'd0) begin
                state_d = StReturn;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
`else
              state_d = StIdle;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = StShift;
            end
          end
        end
        StShift: begin
          state_d = StWaitPs;
          tmr_d   = '0;
        end
        StWaitPs: begin
          if (ps_done) begin
            phase_d = phase_q + 16'd1;
            state_d = StSettle;
            tmr_d   = '0;
            acc_d   = '0;
            wcnt_d  = '0;
          end else if (tmr_q == TmrTimeout) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        StSettle: begin
          // Words are ignored here; acc and wcnt were cleared on entry.
          if (tmr_q == SettleLast) begin
            state_d = StAccum;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
`ifdef ETS_PS_RETURN_EN
        StReturn: begin
          state_d = StWaitRet;
          tmr_d   = '0;
        end
        StWaitRet: begin
          if (ps_done) begin
            phase_d = phase_q - 16'd1;
            if (phase_q == 16'd1) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StReturn;
            end
          end else if (tmr_q == TmrTimeout) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  logic step_state;
`ifdef ETS_PS_RETURN_EN
  assign step_state = (state_q == StShift) || (state_q == StReturn);
`else
  assign step_state = (state_q == StShift);
`endif

  // abort and lock loss leave the state on the next edge; masking here means neither a
  // dropped point nor a dangling phase step is ever presented on the interfaces.
  assign ps_en     = step_state && !abort && locked;
  assign ps_incdec = (state_q == StShift);
  assign out_valid = (state_q == StEmit) && !abort && locked;
  assign out_phase = phase_q;
  assign out_count = acc_q;
  assign out_last  = (state_q == StEmit) && (phase_q == PhaseLast);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ets_phase_sweep.sv
// Self-checking bench for ets_phase_sweep (STEPS=4, ACC_LOG2=2, SETTLE_CYC=4, PS_TIMEOUT=15).
// The MMCM model answers every ps_en with ps_done five cycles later unless withheld.
module tb_ets_phase_sweep;

  localparam int STEPS    = 4;
  localparam int ACC_LOG2 = 2;
  localparam int SETTLE   = 4;
  localparam int TIMEOUT  = 15;
  localparam int PS_LAT   = 5;

`ifdef ETS_PS_RETURN_EN
  localparam bit RetEn = 1'b1;
`else
  localparam bit RetEn = 1'b0;
`endif
  localparam int ExpDec      = RetEn ? STEPS - 1 : 0;
  localparam int ExpGap      = RetEn ? 1 + (PS_LAT + 1) * (STEPS - 1) : 1;
  localparam int ExpEndPhase = RetEn ? 0 : STEPS - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start, abort, locked;
  logic                ps_en, ps_incdec, ps_done;
  logic                smp_valid;
  logic [7:0]          smp_data;
  logic                out_valid, out_ready;
  logic [15:0]         out_phase;
  logic [ACC_LOG2+3:0] out_count;
  logic                out_last, busy, done, err;

  always #5 clk = ~clk;

  ets_phase_sweep #(
    .STEPS     (STEPS),
    .ACC_LOG2  (ACC_LOG2),
    .SETTLE_CYC(SETTLE),
    .PS_TIMEOUT(TIMEOUT)
  ) dut (
    .free_run_clk(clk),
    .free_run_rst(rst),
    .start       (start),
    .abort       (abort),
    .locked      (locked),
    .ps_en       (ps_en),
    .ps_incdec   (ps_incdec),
    .ps_done     (ps_done),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_phase   (out_phase),
    .out_count   (out_count),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Environment: sample source, MMCM model, point monitor (sole writer of these variables).
  int          cyc = 0;
  int          pend = -1;
  int          n_inc = 0, n_dec = 0, overlap = 0;
  int          xfer_cyc = 0;
  int          q_phase[$], q_count[$], q_last[$];
  bit          ps_done_en = 1'b1;
  int          smp_period = 1;
  logic [7:0]  smp_byte = 8'h00;

  initial begin
    ps_done   = 1'b0;
    smp_valid = 1'b0;
    smp_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        q_phase.push_back(int'(out_phase));
        q_count.push_back(int'(out_count));
        q_last.push_back(int'(out_last));
        xfer_cyc = cyc;
      end
      if (ps_en) begin
        if (pend >= 0) overlap++;
        pend = PS_LAT;
        if (ps_incdec) n_inc++;
        else n_dec++;
      end
      @(posedge clk);
      #1;
      cyc++;
      ps_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ps_done = ps_done_en;
          pend = -1;
        end
      end
      smp_valid = (cyc % smp_period) == 0;
      smp_data  = smp_byte;
    end
  end

  typedef struct {
    logic [7:0] data;
    int         period;
    int         exp_count;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int done_cyc = 0;

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ps_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ps_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_phase(input int ph, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (int'(out_phase) == ph) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_sweep(input int vi, input bit hold);
    int base, inc0, dec0, ov0, np, bad, hinc;
    bit ok;
    int s_phase, s_count, s_last;
    base = q_phase.size();
    inc0 = n_inc;
    dec0 = n_dec;
    ov0  = overlap;
    smp_byte   = vecs[vi].data;
    smp_period = vecs[vi].period;
    out_ready  = !hold;
    pulse_start();
    chk($sformatf("v%0d start_busy", vi), int'(busy), 1);
    chk($sformatf("v%0d start_err_clear", vi), int'(err), 0);
    if (hold) begin
      wait_valid(ok);
      chk("hold_valid_seen", int'(ok), 1);
      s_phase = int'(out_phase);
      s_count = int'(out_count);
      s_last  = int'(out_last);
      chk("hold_first_count", s_count, vecs[vi].exp_count);
      bad  = 0;
      hinc = n_inc;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!out_valid || int'(out_phase) != s_phase || int'(out_count) != s_count ||
            int'(out_last) != s_last || ps_en) bad++;
      end
      chk("hold_stable", bad, 0);
      chk("hold_no_ps_en", n_inc - hinc, 0);
      tick();
      out_ready = 1'b1;
    end
    wait_done(ok);
    chk($sformatf("v%0d done_seen", vi), int'(ok), 1);
    chk($sformatf("v%0d done_gap", vi), done_cyc - xfer_cyc, ExpGap);
    np = q_phase.size() - base;
    chk($sformatf("v%0d npoints", vi), np, STEPS);
    for (int i = 0; i < STEPS && i < np; i++) begin
      chk($sformatf("v%0d p%0d phase", vi, i), q_phase[base + i], i);
      chk($sformatf("v%0d p%0d count", vi, i), q_count[base + i], vecs[vi].exp_count);
      chk($sformatf("v%0d p%0d last", vi, i), q_last[base + i], (i == STEPS - 1) ? 1 : 0);
    end
    chk($sformatf("v%0d inc_pulses", vi), n_inc - inc0, STEPS - 1);
    chk($sformatf("v%0d dec_pulses", vi), n_dec - dec0, ExpDec);
    chk($sformatf("v%0d ps_overlap", vi), overlap - ov0, 0);
    chk($sformatf("v%0d end_phase", vi), int'(out_phase), ExpEndPhase);
    chk($sformatf("v%0d err_after", vi), int'(err), 0);
    tick();
    chk($sformatf("v%0d done_pulse_1cyc", vi), int'(done), 0);
    chk($sformatf("v%0d idle_after", vi), int'(busy), 0);
  endtask

  initial begin
    bit ok;
    int base;

    vecs[0] = '{8'hFF, 1, 32};
    vecs[1] = '{8'h01, 2, 4};
    vecs[2] = '{8'hA5, 1, 16};
    vecs[3] = '{8'h0F, 3, 16};
    vecs[4] = '{8'h00, 1, 0};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    locked = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst ps_en", int'(ps_en), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst err", int'(err), 0);
    chk("rst phase", int'(out_phase), 0);
    chk("rst count", int'(out_count), 0);
    chk("rst last", int'(out_last), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Table-driven sweeps.
    for (int v = 0; v < 5; v++) run_sweep(v, 1'b0);

    // Backpressure on the first point.
    run_sweep(0, 1'b1);

    // ps_done withheld: timeout after PS_TIMEOUT cycles of WAIT_PS.
    smp_byte = 8'hFF;
    smp_period = 1;
    ps_done_en = 1'b0;
    pulse_start();
    wait_ps_en(ok);
    chk("to ps_en_seen", int'(ok), 1);
    repeat (15) @(negedge clk);
    chk("to err_before", int'(err), 0);
    chk("to busy_before", int'(busy), 1);
    @(negedge clk);
    chk("to err_set", int'(err), 1);
    chk("to idle", int'(busy), 0);
    chk("to no_done", int'(done), 0);
    ps_done_en = 1'b1;
    repeat (8) tick();
    run_sweep(1, 1'b0);

    // Lock loss during ACCUM of phase 2.
    base = q_phase.size();
    smp_byte = 8'hFF;
    smp_period = 1;
    pulse_start();
    wait_phase(2, ok);
    chk("ll phase2_seen", int'(ok), 1);
    repeat (5) tick();
    locked = 1'b0;
    @(negedge clk);
    tick();
    chk("ll err_set", int'(err), 1);
    chk("ll idle", int'(busy), 0);
    chk("ll no_done", int'(done), 0);
    chk("ll points", q_phase.size() - base, 2);
    // start while unlocked is refused and flags err.
    pulse_start();
    chk("ul err", int'(err), 1);
    chk("ul idle", int'(busy), 0);
    locked = 1'b1;
    run_sweep(2, 1'b0);

    // Abort in EMIT with out_ready asserted on the same cycle.
    base = q_phase.size();
    smp_byte = 8'hFF;
    smp_period = 1;
    out_ready = 1'b0;
    pulse_start();
    wait_valid(ok);
    chk("ab valid_seen", int'(ok), 1);
    tick();
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ab valid_masked", int'(out_valid), 0);
    tick();
    abort = 1'b0;
    chk("ab idle", int'(busy), 0);
    chk("ab err_clear", int'(err), 0);
    chk("ab no_transfer", q_phase.size() - base, 0);
    repeat (3) tick();
    run_sweep(3, 1'b0);

    // Asynchronous reset mid-sweep; the in-flight ps_done arrives in IDLE.
    smp_byte = 8'hFF;
    smp_period = 1;
    pulse_start();
    wait_phase(1, ok);
    chk("mr phase1_seen", int'(ok), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr busy", int'(busy), 0);
    chk("mr phase", int'(out_phase), 0);
    chk("mr count", int'(out_count), 0);
    chk("mr valid", int'(out_valid), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("mr stay_idle", int'(busy), 0);
    run_sweep(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
